// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ byte-stream
// requesters share one transmit FIFO. A requester that wins keeps the grant
// until it sends a byte flagged with last, so its message stays contiguous.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add a stall counter that
// revokes a grant whose owner stops presenting bytes for TIMEOUT cycles and
// raises the sticky timeout_err flag. Without it, a grant is held forever.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   last,
    input  logic [8*NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0]   ack,
    input  logic                 fifo_full,
    output logic                 fifo_write,
    output logic [7:0]           fifo_data,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    // Parameter range guard: an empty block that only exists for illegal
    // configurations, so out-of-range values show up in elaboration reports.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_illegal_params
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] rr_ptr;
    logic [2:0] next_ptr;
    logic [2:0] pick_id;
    logic       pick_valid;
    logic       owner_req;
    logic       owner_last;
    logic [7:0] owner_data;
    logic       xfer;
    logic       timeout_hit;

    // Select the current owner's request, last flag and byte.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                owner_req  = req[i];
                owner_last = last[i];
                owner_data = data[8*i +: 8];
            end
        end
    end

    // Round-robin pick: the requester with the smallest distance from rr_ptr wins.
    always_comb begin
        int best_d;
        int d;
        best_d     = NUM_REQ;
        d          = 0;
        pick_id    = 3'd0;
        pick_valid = |req;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                d = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
                if (d < best_d) begin
                    best_d  = d;
                    pick_id = 3'(i);
                end
            end
        end
    end

    assign next_ptr = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
    assign xfer     = (state == GRANT) && owner_req && !fifo_full;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [7:0] stall_cnt;

    // The cycle that would make the stall count reach TIMEOUT ends the grant.
    assign timeout_hit = (state == GRANT) && !owner_req && (stall_cnt == 8'(TIMEOUT - 1));

    // Count owner-idle cycles; backpressure stalls neither count nor clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (state != GRANT || xfer) begin
                stall_cnt <= 8'd0;
            end else if (!owner_req) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winner on arbitration and advance the pointer when a grant ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id <= 3'd0;
            rr_ptr   <= 3'd0;
        end else begin
            if (state == IDLE && pick_valid) begin
                grant_id <= pick_id;
            end
            if (state == GRANT && state_nxt == IDLE) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    // Next-state logic: a grant ends on a last byte or on timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if ((xfer && owner_last) || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: write strobe and ack follow the transfer condition in the same cycle.
    always_comb begin
        busy       = (state == GRANT);
        fifo_write = xfer;
        fifo_data  = owner_data;
        ack        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer && grant_id == 3'(i)) begin
                ack[i] = 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing the transmit buffer (legal 2..8).
REQ-002 Parameter TIMEOUT, default 16, SHALL set the stall-cycle limit used by the timeout feature (legal 2..255).
REQ-003 clk  input  1  SHALL be the system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req  input  NUM_REQ  SHALL carry one bit per requester; 1 = the requester's byte on data is valid.
REQ-006 last  input  NUM_REQ  SHALL carry one bit per requester; 1 = the current byte ends that requester's message.
REQ-007 data  input  8*NUM_REQ  SHALL carry requester i's byte in bits [8i+7:8i].
REQ-008 ack  output  NUM_REQ  SHALL be one-hot or zero; 1 = requester i's byte was accepted this cycle.
REQ-009 fifo_full  input  1  SHALL be the transmit buffer's full flag.
REQ-010 fifo_write  output  1  SHALL be the one-cycle write strobe to the transmit buffer.
REQ-011 fifo_data  output  8  SHALL be the byte written when fifo_write=1.
REQ-012 grant_id  output  3  SHALL give the index of the current owner; it is valid only while busy=1.
REQ-013 busy  output  1  SHALL be 1 while the arbiter is in GRANT.
REQ-014 timeout_err  output  1  SHALL be a sticky flag that is set on grant timeout.

Function
REQ-015 The FSM SHALL have two states, IDLE and GRANT, held in a state register.
REQ-016 IDLE: if any req bit is 1, the arbiter SHALL select the first requesting index at or after rr_ptr (wrapping modulo NUM_REQ), register it into grant_id, and enter GRANT on the next edge; one cycle of arbitration latency.
REQ-017 IDLE SHALL assert no ack and no fifo_write.
REQ-018 GRANT transfer condition: req[grant_id]=1 and fifo_full=0.
REQ-019 When the transfer condition holds, fifo_write=1, fifo_data=data[grant_id] and ack[grant_id]=1 SHALL all be asserted combinationally in that same cycle.
REQ-020 The arbiter SHALL accept one byte per cycle back-to-back while the transfer condition holds.
REQ-021 With fifo_full=1 in GRANT, the arbiter SHALL assert no write and no ack, hold the grant, and not drop the byte.
REQ-022 A transfer with last[grant_id]=1 SHALL return the FSM to IDLE and load rr_ptr with (grant_id+1) mod NUM_REQ.
REQ-023 The grant SHALL be held for the whole message; when the owner deasserts req without last, the arbiter SHALL keep the grant and stay in GRANT.
REQ-024 Requests from non-owners SHALL be ignored until the FSM returns to IDLE.
REQ-025 The req bits of non-owners SHALL never produce ack or fifo_write.
REQ-026 When the owner's req and last are both 1 while fifo_full=1, the arbiter SHALL complete the message only when fifo_full falls.
REQ-027 rr_ptr SHALL be a 3-bit register; its wrap from NUM_REQ-1 SHALL give 0.
REQ-028 grant_id and fifo_data SHALL hold their last values when not in use; fifo_data is don't-care when fifo_write=0.

Reset
REQ-029 On rst_n=0 the arbiter SHALL immediately enter IDLE and set rr_ptr=0, grant_id=0, busy=0, ack=0, fifo_write=0, timeout_err=0, stall counter=0.
REQ-030 Reset mid-message SHALL abandon the message with no further write; after reset the arbiter SHALL re-arbitrate from index 0.

Configuration
REQ-031 Macro UART_TX_ARB_TIMEOUT_EN defined SHALL enable an 8-bit stall counter in GRANT.
REQ-032 The stall counter SHALL increment on each cycle with req[grant_id]=0 and SHALL clear on any transfer or on entering GRANT; fifo_full stalls SHALL not count.
REQ-033 When the stall counter reaches TIMEOUT, the arbiter SHALL return to IDLE, advance rr_ptr past the owner, and set timeout_err.
REQ-034 timeout_err SHALL clear only on reset.
REQ-035 Macro UART_TX_ARB_TIMEOUT_EN undefined SHALL leave no counter logic; timeout_err SHALL be tied 0 and the grant SHALL be held indefinitely.

Verification
REQ-036 Round-robin: req=4'b1111, each requester sends 1 byte with last=1, fifo_full=0 -> writes in order from requesters 0,1,2,3, then 0 again; one IDLE cycle between grants.
REQ-037 Message atomicity: req0 sends 0x41,0x42,0x43 (last on 0x43) while req2 is held high -> fifo receives 41,42,43 contiguously, then req2's byte; ack[2]=0 throughout req0's message.
REQ-038 Backpressure: fifo_full=1 for 5 cycles while owner 1 presents 0x55 -> fifo_write=0 and ack=0 for 5 cycles; one write of 0x55 on the cycle fifo_full falls.
REQ-039 Wrap: rr_ptr=3 after requester 2 completes, req=4'b0101 -> grant goes to requester 0, then to requester 2.
REQ-040 Timeout (macro defined, TIMEOUT=16): owner 3 sends 0x10 without last, then drops req -> after 16 stall cycles busy=0 and timeout_err=1; the next grant goes to index 0.
REQ-041 Reset mid-message: rst_n pulsed low after 2 of 4 bytes -> all outputs 0 at once; no further write; the next grant starts from index 0.
